// File: rtl/sqrt_if.sv
// Request/result bundle for the iterative square-root unit.
// master: requester driving sqrt_start/sqrt_num; slave: the sqrt unit.
interface sqrt_if #(
    parameter int unsigned IN_W  = 60,
    parameter int unsigned OUT_W = 30
) ();
    logic             sqrt_start;
    logic [IN_W-1:0]  sqrt_num;
    logic             sqrt_ready;
    logic             sqrt_valid;
    logic [OUT_W-1:0] sqrt_sq;
    logic [OUT_W:0]   sqrt_rem;

    modport master (
        output sqrt_start, sqrt_num,
        input  sqrt_ready, sqrt_valid, sqrt_sq, sqrt_rem
    );

    modport slave (
        input  sqrt_start, sqrt_num,
        output sqrt_ready, sqrt_valid, sqrt_sq, sqrt_rem
    );
endinterface

// File: rtl/sqrt_iter.sv
// Iterative integer square root: one root bit per cycle, MSB first.
// Optional macro SQRT_ROUND_EN: sqrt_sq becomes the round-to-nearest root
// (saturating at all-ones); sqrt_rem always reports the floor remainder.
module sqrt_iter #(
    parameter int unsigned sqrt_in_data_size  = 60,
    parameter int unsigned sqrt_out_data_size = 30
) (
    input  logic clk,
    input  logic reset,
    sqrt_if.slave bus
);
    localparam int unsigned IN_W  = sqrt_in_data_size;
    localparam int unsigned OUT_W = sqrt_out_data_size;
    localparam int unsigned REM_W = OUT_W + 2;
    localparam int unsigned CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IN_W-1:0]  num_q,   num_d;
    logic [OUT_W-1:0] root_q,  root_d;
    logic [REM_W-1:0] rem_q,   rem_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] sq_q,    sq_d;
    logic [OUT_W:0]   srem_q,  srem_d;

    logic [REM_W-1:0] rem_shift;
    logic [REM_W-1:0] trial;
    logic [REM_W-1:0] rem_next;
    logic [OUT_W-1:0] root_next;
    logic             bit_ok;
`ifdef SQRT_ROUND_EN
    logic             round_up;
`endif

    // Next-state, datapath step and result formatting
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        root_d  = root_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        sq_d    = sq_q;
        srem_d  = srem_q;

        // Bring down the next two radicand bits and try the candidate bit
        rem_shift = (rem_q << 2) | REM_W'(num_q[IN_W-1 -: 2]);
        trial     = {root_q, 2'b01};
        bit_ok    = (rem_shift >= trial);
        rem_next  = bit_ok ? (rem_shift - trial) : rem_shift;
        root_next = OUT_W'({root_q, bit_ok});
`ifdef SQRT_ROUND_EN
        round_up  = (rem_next > REM_W'(root_next));
`endif

        case (state_q)
            IDLE, DONE: begin
                if (bus.sqrt_start) begin
                    state_d = BUSY;
                    num_d   = bus.sqrt_num;
                    root_d  = '0;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(OUT_W - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                num_d  = num_q << 2;
                root_d = root_next;
                rem_d  = rem_next;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    srem_d  = (OUT_W + 1)'(rem_next);
`ifdef SQRT_ROUND_EN
                    sq_d    = (round_up && !(&root_next)) ? root_next + OUT_W'(1) : root_next;
`else
                    sq_d    = root_next;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d != BUSY);
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            num_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            sq_q    <= '0;
            srem_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            sq_q    <= sq_d;
            srem_q  <= srem_d;
        end
    end

    assign bus.sqrt_ready = ready_q;
    assign bus.sqrt_valid = valid_q;
    assign bus.sqrt_sq    = sq_q;
    assign bus.sqrt_rem   = srem_q;
endmodule

// File: tb/tb_sqrt_iter.sv
// Randomized bench for sqrt_iter against an arithmetic reference model.
module tb_sqrt_iter;
    localparam int unsigned IW = 60;
    localparam int unsigned OW = 30;
    localparam longint unsigned MASK60 = 64'h0FFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sqrt_if #(.IN_W(IW), .OUT_W(OW)) bus ();

    sqrt_iter #(
        .sqrt_in_data_size (IW),
        .sqrt_out_data_size(OW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Floor square root by binary search on the root
    function automatic longint unsigned isqrt(input longint unsigned n);
        longint unsigned lo = 0;
        longint unsigned hi = 64'd1 << OW;
        longint unsigned mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= n) lo = mid;
            else                hi = mid;
        end
        return lo;
    endfunction

    // Root as presented on sqrt_sq for the current build
    function automatic longint unsigned exp_root(input longint unsigned n);
        longint unsigned r = isqrt(n);
`ifdef SQRT_ROUND_EN
        if (n - r * r > r) begin
            r = r + 1;
            if (r == (64'd1 << OW)) r = r - 1;
        end
`endif
        return r;
    endfunction

    function automatic longint unsigned rand60();
        return {$urandom, $urandom} & MASK60;
    endfunction

    // Cycle-level reference: one request in flight, result 30 edges after acceptance
    bit              m_started = 0;
    bit              m_ready   = 1;
    bit              m_valid   = 0;
    longint unsigned m_sq      = 0;
    longint unsigned m_rem     = 0;
    bit              m_pend    = 0;
    longint unsigned m_num     = 0;
    int              m_due     = 0;
    int              cyc       = 0;

    always @(posedge clk) begin
        longint unsigned r;
        cyc++;
        m_started = 1;
        if (reset) begin
            m_pend  = 0;
            m_ready = 1;
            m_valid = 0;
            m_sq    = 0;
            m_rem   = 0;
        end else begin
            m_valid = 0;
            if (m_pend && cyc == m_due) begin
                r       = isqrt(m_num);
                m_pend  = 0;
                m_valid = 1;
                m_sq    = exp_root(m_num);
                m_rem   = m_num - r * r;
            end else if (m_ready && bus.sqrt_start) begin
                m_pend = 1;
                m_num  = 64'(bus.sqrt_num);
                m_due  = cyc + OW;
            end
            m_ready = !m_pend;
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (m_started) begin
            check("cyc_valid", 64'(bus.sqrt_valid), 64'(m_valid));
            check("cyc_ready", 64'(bus.sqrt_ready), 64'(m_ready));
            check("cyc_sq",    64'(bus.sqrt_sq),    m_sq);
            check("cyc_rem",   64'(bus.sqrt_rem),   m_rem);
        end
    end

    // Drive a one-cycle start; entered and left #1 after a rising edge
    task automatic pulse(input longint unsigned n);
        bus.sqrt_start = 1'b1;
        bus.sqrt_num   = IW'(n);
        @(posedge clk); #1;
        bus.sqrt_start = 1'b0;
        bus.sqrt_num   = IW'(rand60());
    endtask

    // Wait (bounded) for sqrt_valid; lat is 1-based cycle count from the accepting edge
    task automatic wait_valid(output int lat, output longint unsigned sq, output longint unsigned rem);
        bit found = 0;
        lat = 0; sq = 0; rem = 0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(posedge clk); #1;
            if (bus.sqrt_valid) begin
                found = 1;
                lat   = k + 1;
                sq    = 64'(bus.sqrt_sq);
                rem   = 64'(bus.sqrt_rem);
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL valid_timeout: got no sqrt_valid expected one within 40 cycles");
        end
    endtask

    task automatic count_valid(input int ncyc, output int cnt);
        cnt = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            if (bus.sqrt_valid) cnt++;
        end
    endtask

    task automatic req(input string name, input longint unsigned n,
                       input longint unsigned esq, input longint unsigned erem);
        int lat;
        longint unsigned sq, rem;
        pulse(n);
        wait_valid(lat, sq, rem);
        check({name, "_lat"}, 64'(lat), 64'd31);
        check({name, "_sq"},  sq,  esq);
        check({name, "_rem"}, rem, erem);
    endtask

    initial begin
        int lat, cnt;
        longint unsigned sq, rem, n, r;

        reset          = 1'b1;
        bus.sqrt_start = 1'b0;
        bus.sqrt_num   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.sqrt_ready), 64'd1);
        check("rst_valid", 64'(bus.sqrt_valid), 64'd0);
        check("rst_sq",    64'(bus.sqrt_sq),    64'd0);
        check("rst_rem",   64'(bus.sqrt_rem),   64'd0);
        reset = 1'b0;

        // Pin the reference model to hand-computed values
        check("model_15",   isqrt(64'd15), 64'd3);
        check("model_8",    isqrt(64'd8),  64'd2);
        check("model_max",  isqrt(MASK60), 64'd1073741823);
        check("model_1e6",  isqrt(64'd1000000), 64'd1000);

        @(posedge clk); #1;

        req("zero", 64'd0, 64'd0, 64'd0);
`ifdef SQRT_ROUND_EN
        req("n15", 64'd15, 64'd4, 64'd6);
        req("n8",  64'd8,  64'd3, 64'd4);
`else
        req("n15", 64'd15, 64'd3, 64'd6);
        req("n8",  64'd8,  64'd2, 64'd4);
`endif
        req("allones", MASK60, 64'd1073741823, 64'd2147483646);

        // Second start while busy must be ignored
        repeat (2) @(posedge clk);
        #1;
        pulse(64'd144);
        repeat (9) @(posedge clk);
        #1;
        bus.sqrt_start = 1'b1;
        bus.sqrt_num   = IW'(64'd99);
        @(posedge clk); #1;
        bus.sqrt_start = 1'b0;
        wait_valid(lat, sq, rem);
        check("busy_lat", 64'(lat + 10), 64'd31);
        check("busy_sq",  sq,  64'd12);
        check("busy_rem", rem, 64'd0);
        count_valid(40, cnt);
        check("busy_no_second_valid", 64'(cnt), 64'd0);

        // Back-to-back: second start issued in the DONE cycle
        n = rand60();
        r = isqrt(n);
        req("b2b_first", n, exp_root(n), n - r * r);
        req("b2b_1e6", 64'd1000000, 64'd1000, 64'd0);

        // Reset mid-operation
        repeat (3) @(posedge clk);
        #1;
        pulse(rand60());
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", 64'(bus.sqrt_ready), 64'd1);
        check("abort_valid", 64'(bus.sqrt_valid), 64'd0);
        check("abort_sq",    64'(bus.sqrt_sq),    64'd0);
        check("abort_rem",   64'(bus.sqrt_rem),   64'd0);
        reset = 1'b0;
        count_valid(40, cnt);
        check("abort_no_valid", 64'(cnt), 64'd0);
        req("after_abort", 64'd49, 64'd7, 64'd0);

        // Random radicands of varied magnitude, with random idle gaps
        for (int i = 0; i < 24; i++) begin
            n = rand60() >> $urandom_range(0, 59);
            r = isqrt(n);
            req("rand", n, exp_root(n), n - r * r);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
